// File: rtl/weight_row_loader.sv
// Streams fixed-point weights into ROWS writable row memories with one-hot write strobes.
// Optional trailing checksum beat is enabled by defining WEIGHT_ROW_LOADER_CKSUM_EN.
module weight_row_loader #(
   parameter int unsigned INT_BITS = 6,
   parameter int unsigned FRC_BITS = 7,
   parameter int unsigned ROWS     = 28,
   parameter int unsigned DEPTH    = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [INT_BITS+FRC_BITS-1:0] s_data,
   input  logic                         s_last,
   output logic [ROWS-1:0]              wr_en,
   output logic [4:0]                   wr_addr,
   output logic [INT_BITS+FRC_BITS-1:0] wr_data,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);

   localparam int unsigned W      = INT_BITS + FRC_BITS;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned ROW_W  = $clog2(ROWS);

`ifdef WEIGHT_ROW_LOADER_CKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERR} state_t;
   logic [W-1:0] cksum;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;
`endif

   state_t            state;
   logic [ROW_W-1:0]  row_cnt;
   logic [ADDR_W-1:0] addr_cnt;
   logic              last_weight;

   assign last_weight = (row_cnt == ROW_W'(ROWS - 1)) && (addr_cnt == ADDR_W'(DEPTH - 1));

   // Handshake and status flags are registered alongside the state they decode.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         row_cnt  <= '0;
         addr_cnt <= '0;
         s_ready  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         wr_en    <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
`ifdef WEIGHT_ROW_LOADER_CKSUM_EN
         cksum    <= '0;
`endif
      end else begin
         wr_en <= '0;
         done  <= 1'b0;
         case (state)
            S_IDLE, S_ERR: begin
               if (start) begin
                  state    <= S_LOAD;
                  s_ready  <= 1'b1;
                  busy     <= 1'b1;
                  err      <= 1'b0;
                  row_cnt  <= '0;
                  addr_cnt <= '0;
`ifdef WEIGHT_ROW_LOADER_CKSUM_EN
                  cksum    <= '0;
`endif
               end
            end
            S_LOAD: begin
               if (s_valid) begin
                  wr_en   <= ROWS'(1) << row_cnt;
                  wr_addr <= addr_cnt;
                  wr_data <= s_data;
`ifdef WEIGHT_ROW_LOADER_CKSUM_EN
                  cksum   <= cksum + s_data;
                  // s_last belongs on the checksum beat, never on the final weight.
                  if (last_weight && !s_last) begin
                     state <= S_CHECK;
                  end else if (s_last || last_weight) begin
                     state   <= S_ERR;
                     err     <= 1'b1;
                     s_ready <= 1'b0;
                     busy    <= 1'b0;
                  end
`else
                  if (last_weight && s_last) begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     s_ready <= 1'b0;
                     busy    <= 1'b0;
                  end else if (last_weight || s_last) begin
                     state   <= S_ERR;
                     err     <= 1'b1;
                     s_ready <= 1'b0;
                     busy    <= 1'b0;
                  end
`endif
                  if (addr_cnt == ADDR_W'(DEPTH - 1)) begin
                     addr_cnt <= '0;
                     row_cnt  <= row_cnt + ROW_W'(1);
                  end else begin
                     addr_cnt <= addr_cnt + ADDR_W'(1);
                  end
               end
            end
`ifdef WEIGHT_ROW_LOADER_CKSUM_EN
            S_CHECK: begin
               if (s_valid) begin
                  s_ready <= 1'b0;
                  busy    <= 1'b0;
                  if (s_last && (s_data == cksum)) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_ERR;
                     err   <= 1'b1;
                  end
               end
            end
`endif
            S_DONE: state <= S_IDLE;
            default: begin
               state   <= S_IDLE;
               s_ready <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weight_row_loader.sv
// Self-checking bench for weight_row_loader: linear-beat-index model plus directed scenarios.
// Define WEIGHT_ROW_LOADER_CKSUM_EN to exercise the checksum build.
module tb_weight_row_loader;

   localparam int unsigned W     = 13;
   localparam int unsigned ROWS  = 28;
   localparam int unsigned DEPTH = 32;
   localparam int          BEATS = ROWS * DEPTH;
`ifdef WEIGHT_ROW_LOADER_CKSUM_EN
   localparam int          LAST_AT = -1;
`else
   localparam int          LAST_AT = BEATS - 1;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            s_valid = 1'b0;
   logic            s_last = 1'b0;
   logic [W-1:0]    s_data = '0;
   logic            s_ready;
   logic [ROWS-1:0] wr_en;
   logic [4:0]      wr_addr;
   logic [W-1:0]    wr_data;
   logic            busy;
   logic            done;
   logic            err;

   weight_row_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   int n_wr   = 0;
   int n_done = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a single beat index drives row (idx/DEPTH) and address (idx%DEPTH).
   localparam int M_IDLE = 0, M_LOAD = 1, M_CHECK = 2, M_DONE = 3, M_ERR = 4;
   int              m_state = M_IDLE;
   int              m_idx   = 0;
   logic [W-1:0]    m_sum   = '0;
   logic [ROWS-1:0] e_wr_en = '0;
   logic [4:0]      e_addr  = '0;
   logic [W-1:0]    e_data  = '0;
   logic            e_done  = 1'b0;
   logic            e_err   = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_state = M_IDLE; m_idx = 0; m_sum = '0;
         e_wr_en = '0; e_done = 1'b0; e_err = 1'b0;
      end else begin
         e_wr_en = '0;
         e_done  = 1'b0;
         case (m_state)
            M_IDLE, M_ERR: if (start) begin
               m_state = M_LOAD; m_idx = 0; m_sum = '0; e_err = 1'b0;
            end
            M_LOAD: if (s_valid) begin
               e_wr_en[m_idx / DEPTH] = 1'b1;
               e_addr = 5'(m_idx % DEPTH);
               e_data = s_data;
               m_sum  = m_sum + s_data;
               if (m_idx == BEATS - 1) begin
`ifdef WEIGHT_ROW_LOADER_CKSUM_EN
                  if (s_last) begin m_state = M_ERR; e_err = 1'b1; end
                  else m_state = M_CHECK;
`else
                  if (s_last) begin m_state = M_DONE; e_done = 1'b1; end
                  else begin m_state = M_ERR; e_err = 1'b1; end
`endif
               end else if (s_last) begin
                  m_state = M_ERR; e_err = 1'b1;
               end
               m_idx++;
            end
            M_CHECK: if (s_valid) begin
               if (s_last && s_data == m_sum) begin m_state = M_DONE; e_done = 1'b1; end
               else begin m_state = M_ERR; e_err = 1'b1; end
            end
            default: m_state = M_IDLE;
         endcase
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         check("wr_en", 32'(wr_en), 32'(e_wr_en));
         if (e_wr_en != '0) begin
            check("wr_addr", 32'(wr_addr), 32'(e_addr));
            check("wr_data", 32'(wr_data), 32'(e_data));
         end
         check("s_ready", 32'(s_ready), 32'(m_state == M_LOAD || m_state == M_CHECK));
         check("busy", 32'(busy), 32'(m_state == M_LOAD || m_state == M_CHECK));
         check("done", 32'(done), 32'(e_done));
         check("err", 32'(err), 32'(e_err));
         if (wr_en != '0) n_wr++;
         if (done) n_done++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic stream(input int n, input int last_at, input int gap, input int start_at,
                         input bit ones);
      int sent = 0;
      int guard = 0;
      bit acc;
      while (sent < n && guard < 20 * n + 100) begin
         s_valid = (gap == 0) || ($urandom_range(99) >= gap);
         s_data  = ones ? W'(1) : W'(sent);
         s_last  = (sent == last_at);
         start   = (sent == start_at);
         @(posedge clk);
         acc = s_valid && s_ready;
         #1;
         if (acc) sent++;
         guard++;
      end
      start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      if (sent < n) check("stream_timeout", 32'(sent), 32'(n));
   endtask

   task automatic send_check(input logic [W-1:0] data, input bit last);
      bit acc = 1'b0;
      s_valid = 1'b1; s_data = data; s_last = last;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(posedge clk);
         acc = s_ready;
         #1;
      end
      s_valid = 1'b0; s_last = 1'b0;
      if (!acc) check("check_beat_timeout", 32'(acc), 32'(1));
   endtask

   // Full load with s_data = beat index; sum of 0..895 mod 8192 is 0x1E40.
   task automatic full_load(input int gap);
      pulse_start();
      stream(BEATS, LAST_AT, gap, -1, 1'b0);
`ifdef WEIGHT_ROW_LOADER_CKSUM_EN
      check("model_sum_idx", 32'(m_sum), 32'h1E40);
      send_check(13'h1E40, 1'b1);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) tick();
      chk_on = 1'b1;
      check("rst_wr_en", 32'(wr_en), 32'h0);
      check("rst_wr_addr", 32'(wr_addr), 32'h0);
      check("rst_wr_data", 32'(wr_data), 32'h0);
      check("rst_s_ready", 32'(s_ready), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done_err", {30'h0, done, err}, 32'h0);
      rst_n = 1'b1;
      tick();

      // Full load, s_valid always high.
      n_wr = 0; n_done = 0;
      full_load(0);
`ifndef WEIGHT_ROW_LOADER_CKSUM_EN
      check("t1_last_wr_en", 32'(wr_en), 32'h0800_0000);
      check("t1_last_addr", 32'(wr_addr), 32'd31);
      check("t1_last_data", 32'(wr_data), 32'h37F);
`endif
      check("t1_done_pulse", 32'(done), 32'h1);
      tick();
      check("t1_done_low", 32'(done), 32'h0);
      repeat (3) tick();
      check("t1_writes", 32'(n_wr), 32'(BEATS));
      check("t1_done_count", 32'(n_done), 32'h1);
      check("t1_err", 32'(err), 32'h0);

      // Full load with 50% s_valid gaps.
      n_wr = 0; n_done = 0;
      pulse_start();
      stream(BEATS, LAST_AT, 50, -1, 1'b0);
`ifdef WEIGHT_ROW_LOADER_CKSUM_EN
      send_check(13'h1E40, 1'b1);
`endif
      repeat (3) tick();
      check("t2_writes", 32'(n_wr), 32'(BEATS));
      check("t2_done_count", 32'(n_done), 32'h1);

      // Early s_last on beat 40, then restart.
      pulse_start();
      stream(41, 40, 0, -1, 1'b0);
      check("t3_wr_en", 32'(wr_en), 32'h2);
      check("t3_wr_addr", 32'(wr_addr), 32'd8);
      check("t3_wr_data", 32'(wr_data), 32'd40);
      check("t3_err", 32'(err), 32'h1);
      check("t3_s_ready", 32'(s_ready), 32'h0);
      s_valid = 1'b1; s_last = 1'b1;
      repeat (3) tick();
      s_valid = 1'b0; s_last = 1'b0;
      check("t3_err_sticky", 32'(err), 32'h1);
      n_wr = 0; n_done = 0;
      full_load(0);
      repeat (3) tick();
      check("t3_restart_writes", 32'(n_wr), 32'(BEATS));
      check("t3_restart_done", 32'(n_done), 32'h1);

      // Missing s_last at the end; start mid-stream is ignored.
      n_wr = 0; n_done = 0;
      pulse_start();
      stream(BEATS, -1, 0, 300, 1'b0);
`ifdef WEIGHT_ROW_LOADER_CKSUM_EN
      send_check(13'h1E40, 1'b0);
`endif
      check("t4_err", 32'(err), 32'h1);
      repeat (2) tick();
      check("t4_writes", 32'(n_wr), 32'(BEATS));
      check("t4_no_done", 32'(n_done), 32'h0);

      // Reset at beat 500 drops the pending write, then restart.
      pulse_start();
      stream(500, -1, 0, -1, 1'b0);
      s_valid = 1'b1; s_data = W'(500); rst_n = 1'b0;
      tick();
      check("t5_wr_en", 32'(wr_en), 32'h0);
      check("t5_wr_addr", 32'(wr_addr), 32'h0);
      check("t5_wr_data", 32'(wr_data), 32'h0);
      check("t5_flags", {28'h0, s_ready, busy, done, err}, 32'h0);
      rst_n = 1'b1; s_valid = 1'b0;
      tick();
      n_wr = 0; n_done = 0;
      full_load(0);
      repeat (3) tick();
      check("t5_restart_writes", 32'(n_wr), 32'(BEATS));
      check("t5_restart_done", 32'(n_done), 32'h1);

`ifdef WEIGHT_ROW_LOADER_CKSUM_EN
      // All-ones weights: checksum 896 = 0x380.
      pulse_start();
      stream(BEATS, -1, 0, -1, 1'b1);
      check("t6_model_sum", 32'(m_sum), 32'h380);
      send_check(13'h0380, 1'b1);
      check("t6_done", 32'(done), 32'h1);
      tick();
      pulse_start();
      stream(BEATS, -1, 0, -1, 1'b1);
      send_check(13'h0381, 1'b1);
      check("t6_bad_sum_err", 32'(err), 32'h1);
      pulse_start();
      stream(BEATS, BEATS - 1, 0, -1, 1'b1);
      check("t6_last_on_weight_err", 32'(err), 32'h1);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/weight_row_loader.md
# weight_row_loader

Streaming writer for the per-block weight row memories in the neural datapath. Accepts a flat valid/ready stream of fixed-point weights, walks row number and address in order, and issues one-hot write strobes into the ROWS writable row memories that replace the hard-coded weight tables. Completion or framing error is reported to the controller; the read side of each row memory is unchanged: 5-bit address, one-cycle registered read.

## Interface
- INT_BITS, 6, integer bits of a weight
- FRC_BITS, 7, fractional bits of a weight; word width W = INT_BITS+FRC_BITS (13)
- ROWS, 28, number of row memories (block numbers 0..ROWS-1)
- DEPTH, 32, entries per row; address width fixed at 5

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse, begins a load from IDLE or ERR
- s_valid  in  1  input word valid
- s_ready  out  1  loader accepts word this cycle
- s_data  in  W  weight, two's-complement fixed point
- s_last  in  1  marks final beat of the load
- wr_en  out  ROWS  one-hot write strobe, bit N selects row memory N
- wr_addr  out  5  write address
- wr_data  out  W  write data
- busy  out  1  high in LOAD (and CHECK)
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky framing/checksum error

## Operation
- States: IDLE, LOAD, CHECK (macro only), DONE, ERR.
- IDLE: s_ready=0. start -> LOAD; row_cnt=0, addr_cnt=0, checksum cleared.
- LOAD: s_ready=1. Accept = s_valid & s_ready. Each accept writes s_data to row row_cnt, address addr_cnt.
- Order: address 0..DEPTH-1 within a row, then next row; addr_cnt wraps DEPTH-1 -> 0 and row_cnt increments. Total ROWS*DEPTH = 896 beats.
- Final weight beat (row_cnt=ROWS-1, addr_cnt=DEPTH-1): written; s_last=1 -> DONE, s_last=0 -> ERR (macro off).
- s_last=1 on any earlier beat: word is written, -> ERR.
- DONE: done=1 for exactly one cycle, -> IDLE.
- ERR: err=1, s_ready=0, no writes. start -> LOAD (restart from row 0, err cleared). Other inputs ignored.
- start while in LOAD/CHECK/DONE ignored.
- Writes are never undone: partial loads leave earlier entries in memory.

## Timing
- Reset values: state IDLE, s_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, counters 0.
- s_ready, busy decoded from registered state only; no combinational path from s_valid.
- Write latency: accept at edge k -> wr_en/wr_addr/wr_data valid for the cycle after edge k, exactly one cycle; wr_en=0 otherwise.
- Back-to-back accepts give back-to-back writes; s_valid gaps give wr_en=0 gaps.
- done asserts the cycle after the final accept edge; err asserts the cycle after the offending accept edge.
- Minimum load time: 896 cycles + 1 (DONE) with s_valid held high.
- Reset mid-load: at the rst_n edge all outputs return to reset values; a write pending from the previous accept is dropped.

## Configuration
- WEIGHT_ROW_LOADER_CKSUM_EN defined: running checksum = sum of all weights mod 2^W. After the final weight beat, state -> CHECK (s_ready=1, no write). s_last must be on the CHECK beat, not on the final weight; a s_last on the final weight -> ERR. CHECK beat: s_data == checksum and s_last=1 -> DONE, otherwise -> ERR. Total beats 897.
- Not defined: no checksum logic, no CHECK state, behaviour as in Operation.

## Test plan
- Full load, s_valid always high, s_data = beat index mod 8192, s_last on beat 895 -> wr_en one-hot bit index/32, wr_addr index%32, done pulse 1 cycle after last accept, err=0.
- Random s_valid gaps (50%) over full load -> exactly 896 write cycles, same data/address sequence, done once.
- s_last on beat 40 -> row 1 addr 8 written, err=1 next cycle, s_ready=0; then start -> load from row 0 addr 0 succeeds.
- Missing s_last on beat 895 -> err=1, no done; start in LOAD mid-stream ignored (counters continue).
- rst_n low for one cycle at beat 500 -> all outputs 0 next cycle, state IDLE; start restarts at row 0 addr 0.
- Macro on: 896 weights of 13'h0001 then checksum beat 13'h0380 with s_last -> done; checksum beat 13'h0381 -> err.
